instr_mem_ctrl: RTL and testbench
=================================

# instr_mem_ctrl

Parametrised, synchronous instruction memory for the CPU fetch stage, replacing the combinational 16-bit instruction store. It holds DEPTH words of DATA_W bits, is written through a load port (program download before or between runs), and serves fetches through a valid/ready handshake with a one-cycle registered read and a holding output register that absorbs pipeline stalls. It sits between the PC/fetch logic and the decode stage.

## Interface
- DATA_W, 16, instruction word width
- ADDR_W, 16, fetch/load address width (word addresses)
- DEPTH, 256, number of words stored; 2 ≤ DEPTH ≤ 2^ADDR_W
- NOP_WORD, 16'h0000, word returned on faulting fetch (width DATA_W)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- fetch_req  in  1  fetch request valid
- fetch_addr  in  ADDR_W  word address of requested instruction
- fetch_ready  out  1  request accepted this cycle when fetch_req && fetch_ready
- instr_valid  out  1  instr holds a returned word
- instr  out  DATA_W  returned instruction
- instr_ack  in  1  consumer takes instr this cycle when instr_valid && instr_ack
- instr_fault  out  1  returned word came from an out-of-range address (IMEM_FAULT_EN only, else 0)
- load_en  in  1  write load_data into memory this cycle
- load_addr  in  ADDR_W  load word address
- load_data  in  DATA_W  load word
- load_busy  out  1  registered copy of load_en; fetches blocked while 1

## Operation
- Storage: DEPTH × DATA_W array; contents are NOT affected by rst; uninitialised contents undefined.
- fetch_ready = !load_en && !load_busy && (!instr_valid || instr_ack) (combinational).
- Accept (fetch_req && fetch_ready): array read at fetch_addr; next cycle instr_valid=1, instr=word, instr_fault per range check.
- Hold: while instr_valid && !instr_ack, instr/instr_fault/instr_valid unchanged; no new request accepted.
- Ack without new accept: instr_valid→0 next cycle; instr retains last value.
- Ack and accept same cycle: back-to-back, instr_valid stays 1, new word next cycle (full throughput, 1 word/cycle).
- Load: when load_en, mem[load_addr mod DEPTH] ← load_data (out-of-range load ignored under IMEM_FAULT_EN). Load always wins over fetch; a word already in instr is unaffected by a later load to the same address.
- Range: address ≥ DEPTH handling set by IMEM_FAULT_EN (Configuration).
- States (implicit via instr_valid/load_busy): EMPTY (valid=0), FULL (valid=1), LOADING (load_en||load_busy). EMPTY→FULL on accept; FULL→EMPTY on ack w/o accept; FULL→FULL on ack+accept or hold; any→LOADING on load_en, LOADING exits one cycle after load_en drops.

## Timing
- Reset values: instr_valid=0, instr=NOP_WORD, instr_fault=0, load_busy=0; fetch_ready=1 in the cycle after rst deasserts (if load_en=0).
- rst mid-operation: any pending/held instruction discarded, no instr_valid next cycle; memory contents preserved; a load_en during rst still writes.
- Fetch latency: exactly 1 cycle accept→instr_valid.
- Load-to-fetch: first fetch accepted the cycle after load_busy falls (2 cycles after final load_en); sees the loaded data.
- fetch_req/fetch_addr need not stay stable while fetch_ready=0; nothing is queued.

## Configuration
- IMEM_FAULT_EN defined: fetch_addr ≥ DEPTH returns instr=NOP_WORD with instr_fault=1 (same latency/handshake); loads with load_addr ≥ DEPTH are dropped.
- IMEM_FAULT_EN undefined: addresses wrap modulo DEPTH for fetch and load; instr_fault tied to 0.

## Test plan
- Reset: assert rst 2 cycles with a held word present → instr_valid=0, instr=16'h0000, instr_fault=0, fetch_ready=1 after release.
- Load then stream: load mem[0..3]=16'hA000..16'hA003, then fetch_req 0..3 back-to-back with instr_ack=1 → instr_valid 4 consecutive cycles, instr=A000,A001,A002,A003, one cycle after each accept.
- Stall: fetch addr 1, hold instr_ack=0 for 3 cycles → instr=A001 stable, fetch_ready=0; ack in cycle 4 with fetch addr 2 → A002 next cycle.
- Load priority: fetch_req and load_en (addr 2, data 16'hBEEF) same cycle → fetch_ready=0, no accept; fetch addr 2 after load_busy drops → instr=16'hBEEF.
- Range (DEPTH=256): fetch addr 16'h0105 with IMEM_FAULT_EN → instr=16'h0000, instr_fault=1; without → instr=mem[5], instr_fault=0.
- Reset mid-stall: instr_valid=1 unacked, assert rst → instr_valid=0 next cycle; then fetch addr 0 → A000 (memory kept).

Source files
------------

// File: rtl/instr_mem_ctrl_if.sv
// ----------------------------------------------------------------------------
// instr_mem_ctrl_if
// Fetch, return and load signals between the PC/fetch logic and the
// synchronous instruction memory.
//   master : PC/fetch side. Drives fetch_req/fetch_addr, instr_ack and the
//            load port. Observes fetch_ready, instr_valid/instr/instr_fault
//            and load_busy.
//   slave  : memory side (instr_mem_ctrl), the mirror image of master.
// ----------------------------------------------------------------------------
interface instr_mem_ctrl_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 16
) ();

   // fetch request channel
   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_ready;

   // instruction return channel
   logic              instr_valid;
   logic [DATA_W-1:0] instr;
   logic              instr_fault;
   logic              instr_ack;

   // program load port
   logic              load_en;
   logic [ADDR_W-1:0] load_addr;
   logic [DATA_W-1:0] load_data;
   logic              load_busy;

   modport master (
      output fetch_req,
      output fetch_addr,
      input  fetch_ready,
      input  instr_valid,
      input  instr,
      input  instr_fault,
      output instr_ack,
      output load_en,
      output load_addr,
      output load_data,
      input  load_busy
   );

   modport slave (
      input  fetch_req,
      input  fetch_addr,
      output fetch_ready,
      output instr_valid,
      output instr,
      output instr_fault,
      input  instr_ack,
      input  load_en,
      input  load_addr,
      input  load_data,
      output load_busy
   );

endinterface : instr_mem_ctrl_if

// File: rtl/instr_mem_ctrl.sv
// ----------------------------------------------------------------------------
// instr_mem_ctrl
// Synchronous instruction memory for the fetch stage. It holds DEPTH words of
// DATA_W bits and has a load port for program download. Fetches use a
// valid/ready handshake. The read is registered straight into a holding
// register, so there is one cycle from accept to instr_valid, and a stalled
// decode stage keeps its word until it acks. Ack and accept in the same
// cycle streams one word per cycle.
//
// Ports
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high. Clears the handshake state only; the
//          memory array keeps its contents.
//   bus  : instr_mem_ctrl_if.slave
//          fetch_req/fetch_addr/fetch_ready  fetch request
//                                            (fetch_ready is combinational)
//          instr_valid/instr/instr_fault     returned word (registered)
//          instr_ack                         consumer takes the word
//          load_en/load_addr/load_data       memory write, wins over fetch
//          load_busy                         load_en delayed one cycle
//
// Build option
//   IMEM_FAULT_EN  defined   : a fetch at an address >= DEPTH returns NOP_WORD
//                              with instr_fault=1, and a load at an address
//                              >= DEPTH is dropped.
//                  undefined : fetch and load addresses wrap modulo DEPTH, and
//                              instr_fault is always 0.
// ----------------------------------------------------------------------------
module instr_mem_ctrl #(
   parameter int unsigned       DATA_W   = 16,
   parameter int unsigned       ADDR_W   = 16,
   parameter int unsigned       DEPTH    = 256,
   parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
   input  logic            clk,
   input  logic            rst,
   instr_mem_ctrl_if.slave bus
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // One bit wider than an address, so that DEPTH == 2**ADDR_W still fits
   // for range compares and modulo.
   localparam int unsigned CMP_W = ADDR_W + 1;

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic              load_busy_q;
   logic [DATA_W-1:0] instr_q;
   logic              fault_q;

   logic              fetch_ready_c;
   logic              accept_c;
   logic              fetch_oob_c;
   logic              load_ok_c;
   logic [IDX_W-1:0]  fetch_idx_c;
   logic [IDX_W-1:0]  load_idx_c;

   logic [DATA_W-1:0] mem [DEPTH];

`ifdef IMEM_FAULT_EN
   // Range check against DEPTH. In-range addresses index the array directly.
   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return CMP_W'(a) < CMP_W'(DEPTH);
   endfunction

   assign fetch_oob_c = !in_range(bus.fetch_addr);
   assign load_ok_c   = in_range(bus.load_addr);
   // An out-of-range fetch may truncate to a bogus index; the NOP mux masks
   // the word that is read.
   assign fetch_idx_c = IDX_W'(bus.fetch_addr);
   assign load_idx_c  = IDX_W'(bus.load_addr);
`else
   // Address modulo DEPTH. This is a plain truncation when DEPTH is a
   // power of two.
   function automatic logic [IDX_W-1:0] wrap_idx(input logic [ADDR_W-1:0] a);
      if ((DEPTH & (DEPTH - 1)) == 0) begin
         return IDX_W'(a);
      end
      return IDX_W'(CMP_W'(a) % CMP_W'(DEPTH));
   endfunction

   assign fetch_oob_c = 1'b0;
   assign load_ok_c   = 1'b1;
   assign fetch_idx_c = wrap_idx(bus.fetch_addr);
   assign load_idx_c  = wrap_idx(bus.load_addr);
`endif

   // Program load. Reset does not block it, and reset leaves stored words
   // untouched.
   always_ff @(posedge clk) begin : mem_write
      if (bus.load_en && load_ok_c) begin
         mem[load_idx_c] <= bus.load_data;
      end
   end

   // Holding-register state and load-busy flag.
   always_ff @(posedge clk) begin : state_reg
      if (rst) begin
         state_q     <= S_EMPTY;
         load_busy_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         load_busy_q <= bus.load_en;
      end
   end

   // Handshake and next state. Loads block fetches in the cycle they occur
   // and in the cycle after, so a fetch never meets a write to the array.
   always_comb begin : next_state
      state_d       = state_q;
      fetch_ready_c = 1'b0;
      accept_c      = 1'b0;

      fetch_ready_c = !bus.load_en && !load_busy_q &&
                      ((state_q == S_EMPTY) || bus.instr_ack);
      accept_c      = bus.fetch_req && fetch_ready_c;

      unique case (state_q)
         S_EMPTY: begin
            if (accept_c) begin
               state_d = S_FULL;
            end
         end
         S_FULL: begin
            // Ack with a new accept keeps the register full (streaming).
            if (bus.instr_ack && !accept_c) begin
               state_d = S_EMPTY;
            end
         end
         default: begin
            state_d = S_EMPTY;
         end
      endcase
   end

   // Registered read into the holding register. The word changes only on
   // accept, so after an ack with no new accept the last word stays in place.
   always_ff @(posedge clk) begin : read_reg
      if (rst) begin
         instr_q <= NOP_WORD;
         fault_q <= 1'b0;
      end else if (accept_c) begin
         instr_q <= fetch_oob_c ? NOP_WORD : mem[fetch_idx_c];
         fault_q <= fetch_oob_c;
      end
   end

   assign bus.fetch_ready = fetch_ready_c;
   assign bus.instr_valid = (state_q == S_FULL);
   assign bus.instr       = instr_q;
   assign bus.instr_fault = fault_q;
   assign bus.load_busy   = load_busy_q;

endmodule : instr_mem_ctrl

// File: tb/tb_instr_mem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_instr_mem_ctrl
// Cycle table of {inputs, expected ready/valid} rows. Each accepted fetch
// pushes its expected word onto a scoreboard queue. The returned word is
// compared against the head of the queue, and the entry is popped when the
// consumer acks. Hand-written sequences cover reset during a stall.
// ----------------------------------------------------------------------------
module tb_instr_mem_ctrl;

`ifdef IMEM_FAULT_EN
   localparam bit FE = 1'b1;
`else
   localparam bit FE = 1'b0;
`endif

   typedef struct {
      logic        ld;
      logic [15:0] la;
      logic [15:0] ldat;
      logic        req;
      logic [15:0] fa;
      logic        ack;
      logic        rdy;   // expected fetch_ready this cycle
      logic        vld;   // expected instr_valid this cycle
      logic [15:0] w;     // word expected back if this row is accepted
      logic        f;     // fault expected back if this row is accepted
   } vec_t;

   typedef struct {
      logic [15:0] w;
      logic        f;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   logic prev_ld  = 1'b0;
   exp_t sb[$];
   vec_t tbl[$];

   instr_mem_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus ();

   instr_mem_ctrl #(
      .DATA_W  (16),
      .ADDR_W  (16),
      .DEPTH   (256),
      .NOP_WORD(16'h0000)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic ld, input logic [15:0] la, input logic [15:0] ldat,
                               input logic req, input logic [15:0] fa, input logic ack,
                               input logic rdy, input logic vld,
                               input logic [15:0] w, input logic f);
      vec_t v;
      v.ld = ld; v.la = la; v.ldat = ldat; v.req = req; v.fa = fa; v.ack = ack;
      v.rdy = rdy; v.vld = vld; v.w = w; v.f = f;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.load_en    = v.ld;
      bus.load_addr  = v.la;
      bus.load_data  = v.ldat;
      bus.fetch_req  = v.req;
      bus.fetch_addr = v.fa;
      bus.instr_ack  = v.ack;
   endtask

   // One cycle: drive at negedge, check 1 time unit later, update scoreboard.
   task automatic apply_row(input string tag, input vec_t v);
      @(negedge clk);
      drive(v);
      #1;
      chk({tag, " fetch_ready"}, 16'(bus.fetch_ready), 16'(v.rdy));
      chk({tag, " instr_valid"}, 16'(bus.instr_valid), 16'(v.vld));
      chk({tag, " load_busy"},   16'(bus.load_busy),   16'(prev_ld));
      if (v.vld) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
         end else begin
            chk({tag, " instr"},       bus.instr,              sb[0].w);
            chk({tag, " instr_fault"}, 16'(bus.instr_fault),   16'(sb[0].f));
            if (v.ack) void'(sb.pop_front());
         end
      end
      if (v.req && v.rdy) begin
         exp_t e;
         e.w = v.w;
         e.f = v.f;
         sb.push_back(e);
      end
      prev_ld = v.ld;
   endtask

   // Two reset cycles, with an optional load in the first one. The state is
   // then checked right after release.
   task automatic do_reset(input string tag, input logic ld, input logic [15:0] la,
                           input logic [15:0] ldat);
      @(negedge clk);
      rst = 1'b1;
      drive(mk(ld, la, ldat, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0));
      @(negedge clk);
      drive(mk(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0));
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk({tag, " rst instr_valid"}, 16'(bus.instr_valid), 16'h0);
      chk({tag, " rst instr"},       bus.instr,            16'h0000);
      chk({tag, " rst instr_fault"}, 16'(bus.instr_fault), 16'h0);
      chk({tag, " rst load_busy"},   16'(bus.load_busy),   16'h0);
      chk({tag, " rst fetch_ready"}, 16'(bus.fetch_ready), 16'h1);
      sb.delete();
      prev_ld = 1'b0;
   endtask

   initial begin
      // ld  la       ldat     req fa       ack rdy vld word                    flt
      // load mem[0..3], then stream 0..3 (the first request is blocked by load_busy)
      tbl.push_back(mk(1, 16'h0000, 16'hA000, 0, 16'h0000, 0, 0, 0, 16'h0, 0));
      tbl.push_back(mk(1, 16'h0001, 16'hA001, 0, 16'h0000, 0, 0, 0, 16'h0, 0));
      tbl.push_back(mk(1, 16'h0002, 16'hA002, 0, 16'h0000, 0, 0, 0, 16'h0, 0));
      tbl.push_back(mk(1, 16'h0003, 16'hA003, 0, 16'h0000, 0, 0, 0, 16'h0, 0));
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 16'h0000, 1, 0, 0, 16'h0, 0));
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 16'h0000, 1, 1, 0, 16'hA000, 0));
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 16'h0001, 1, 1, 1, 16'hA001, 0));
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 16'h0002, 1, 1, 1, 16'hA002, 0));
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 16'h0003, 1, 1, 1, 16'hA003, 0));
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 1, 1, 16'h0, 0));
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h0, 0));
      // stall: fetch 1, three unacked cycles, then ack together with fetch 2
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 16'h0001, 0, 1, 0, 16'hA001, 0));
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 16'h0002, 0, 0, 1, 16'h0, 0));
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 16'h0002, 0, 0, 1, 16'h0, 0));
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 16'h0002, 0, 0, 1, 16'h0, 0));
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 16'h0002, 1, 1, 1, 16'hA002, 0));
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h0, 0));
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 1, 1, 16'h0, 0));
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h0, 0));
      // load priority: a load and a fetch in the same cycle
      tbl.push_back(mk(1, 16'h0002, 16'hBEEF, 1, 16'h0002, 0, 0, 0, 16'h0, 0));
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 16'h0002, 0, 0, 0, 16'h0, 0));
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 16'h0002, 0, 1, 0, 16'hBEEF, 0));
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 1, 1, 16'h0, 0));
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h0, 0));
      // range: mem[5] loaded, then fetch 0x0105
      tbl.push_back(mk(1, 16'h0005, 16'h5555, 0, 16'h0000, 0, 0, 0, 16'h0, 0));
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0, 0));
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 16'h0105, 0, 1, 0, FE ? 16'h0000 : 16'h5555, FE));
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 1, 1, 16'h0, 0));
      // load at 0x0103: dropped with faults enabled, otherwise written to mem[3]
      tbl.push_back(mk(1, 16'h0103, 16'h7777, 0, 16'h0000, 0, 0, 0, 16'h0, 0));
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0, 0));
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 16'h0003, 0, 1, 0, FE ? 16'hA003 : 16'h7777, 0));
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 1, 1, 16'h0, 0));
      // first address past the end (DEPTH = 256)
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 16'h0100, 0, 1, 0, FE ? 16'h0000 : 16'hA000, FE));
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 1, 1, 16'h0, 0));
      // a held word is not changed by a later load to the same address
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 16'h0001, 0, 1, 0, 16'hA001, 0));
      tbl.push_back(mk(1, 16'h0001, 16'h1111, 0, 16'h0000, 0, 0, 1, 16'h0, 0));
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h0, 0));
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 1, 1, 16'h0, 0));
      tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h0, 0));

      do_reset("init", 1'b0, 16'h0000, 16'h0000);

      for (int i = 0; i < tbl.size(); i++) begin
         apply_row($sformatf("row%0d", i), tbl[i]);
      end

      // reset during a stall: the held word is dropped and memory is kept.
      // A load during reset still writes.
      apply_row("stall0", mk(0, 16'h0, 16'h0, 1, 16'h0000, 0, 1, 0, 16'hA000, 0));
      apply_row("stall1", mk(0, 16'h0, 16'h0, 0, 16'h0000, 0, 0, 1, 16'h0, 0));
      do_reset("midstall", 1'b1, 16'h0006, 16'h6666);
      apply_row("post0", mk(0, 16'h0, 16'h0, 1, 16'h0000, 0, 1, 0, 16'hA000, 0));
      apply_row("post1", mk(0, 16'h0, 16'h0, 1, 16'h0006, 1, 1, 1, 16'h6666, 0));
      apply_row("post2", mk(0, 16'h0, 16'h0, 0, 16'h0000, 1, 1, 1, 16'h0, 0));
      apply_row("post3", mk(0, 16'h0, 16'h0, 0, 16'h0000, 0, 1, 0, 16'h0, 0));
      // after an ack with no new accept, instr keeps the last word
      chk("post3 instr retained", bus.instr, 16'h6666);
      chk("scoreboard drained", 16'(sb.size()), 16'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_instr_mem_ctrl
